// File: rtl/store_buffer.sv
// Store buffer: a circular FIFO that decouples stores from the data memory port.
// Loads take priority on the port. A load that hits the word of a pending store stalls instead.
module store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 9
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       Store_Valid,
    output logic                       Store_Ready,
    input  logic [ADDR_W-1:0]          Store_Address,
    input  logic [31:0]                Store_Data,
    input  logic [1:0]                 Store_Byte,
    input  logic                       Load_Valid,
    input  logic [ADDR_W-1:0]          Load_Address,
    output logic                       Load_Stall,
    output logic                       Mem_Write,
    output logic [ADDR_W-1:0]          Mem_Address,
    output logic [31:0]                Mem_Data,
    output logic [1:0]                 Mem_Byte,
    output logic                       Buffer_Empty,
    output logic [$clog2(DEPTH):0]     Count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [1:0]        size_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PtrW-1:0]   head_q, head_d;
    logic [PtrW-1:0]   tail_q, tail_d;
    logic [CntW-1:0]   count_q, count_d;

    logic push;
    logic drain;
    logic entry_hit;
    logic push_hit;

    assign Store_Ready  = (count_q != CntW'(DEPTH));
    assign Buffer_Empty = (count_q == '0);
    assign Count        = count_q;
    assign push         = Store_Valid && Store_Ready;

    // Word-granular hazard detection against every live entry and the incoming store.
    always_comb begin
        entry_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i][ADDR_W-1:2] == Load_Address[ADDR_W-1:2])) begin
                entry_hit = 1'b1;
            end
        end
    end

    assign push_hit   = push && (Store_Address[ADDR_W-1:2] == Load_Address[ADDR_W-1:2]);
    assign Load_Stall = Load_Valid && (entry_hit || push_hit);

    // A stalled load yields the port so the blocking store can leave.
    assign drain = (count_q != '0) && (!Load_Valid || Load_Stall);

    always_comb begin
        Mem_Write   = 1'b0;
        Mem_Address = Load_Address;
        Mem_Data    = '0;
        Mem_Byte    = '0;
        if (drain) begin
            Mem_Write   = !reset;
            Mem_Address = addr_q[head_q];
            Mem_Data    = data_q[head_q];
            Mem_Byte    = size_q[head_q];
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        unique case ({push, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload storage needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= Store_Address;
            data_q[tail_q] <= Store_Data;
            size_q[tail_q] <= Store_Byte;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a scoreboard queue of expected memory writes
// checked by an independent monitor, plus inline checks of status outputs.
module tb_store_buffer;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              Store_Valid;
    logic              Store_Ready;
    logic [ADDR_W-1:0] Store_Address;
    logic [31:0]       Store_Data;
    logic [1:0]        Store_Byte;
    logic              Load_Valid;
    logic [ADDR_W-1:0] Load_Address;
    logic              Load_Stall;
    logic              Mem_Write;
    logic [ADDR_W-1:0] Mem_Address;
    logic [31:0]       Mem_Data;
    logic [1:0]        Mem_Byte;
    logic              Buffer_Empty;
    logic [2:0]        Count;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [1:0]        size;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .Store_Valid  (Store_Valid),
        .Store_Ready  (Store_Ready),
        .Store_Address(Store_Address),
        .Store_Data   (Store_Data),
        .Store_Byte   (Store_Byte),
        .Load_Valid   (Load_Valid),
        .Load_Address (Load_Address),
        .Load_Stall   (Load_Stall),
        .Mem_Write    (Mem_Write),
        .Mem_Address  (Mem_Address),
        .Mem_Data     (Mem_Data),
        .Mem_Byte     (Mem_Byte),
        .Buffer_Empty (Buffer_Empty),
        .Count        (Count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                         input logic [1:0] b, input bit expect_wr);
        Store_Valid   = 1'b1;
        Store_Address = a;
        Store_Data    = d;
        Store_Byte    = b;
        if (expect_wr) sb.push_back('{addr: a, data: d, size: b});
    endtask

    task automatic wait_empty(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (Buffer_Empty) break;
        end
        chk("drain_done", 32'(Buffer_Empty), 32'd1);
    endtask

    // Monitor: every memory write must match the oldest expected store.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (Mem_Write === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, expected none",
                             Mem_Address, Mem_Data);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", 32'(Mem_Address), 32'(e.addr));
                    chk("wr_data", Mem_Data, e.data);
                    chk("wr_size", 32'(Mem_Byte), 32'(e.size));
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        Store_Valid   = 1'b0;
        Store_Address = '0;
        Store_Data    = '0;
        Store_Byte    = '0;
        Load_Valid    = 1'b0;
        Load_Address  = '0;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(Store_Ready), 32'd1);
        chk("rst_empty", 32'(Buffer_Empty), 32'd1);
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_memwr", 32'(Mem_Write), 32'd0);
        chk("rst_stall", 32'(Load_Stall), 32'd0);

        // Single word store drains on the following cycle.
        tick();
        store(9'h004, 32'h1234_5678, 2'b00, 1'b1);
        @(negedge clk);
        chk("t1_ready", 32'(Store_Ready), 32'd1);
        tick();
        Store_Valid = 1'b0;
        @(negedge clk);
        chk("t1_count", 32'(Count), 32'd1);
        chk("t1_memwr", 32'(Mem_Write), 32'd1);
        tick();
        @(negedge clk);
        chk("t1_empty", 32'(Buffer_Empty), 32'd1);

        // Fill under a non-matching load, then drain in order.
        tick();
        Load_Valid   = 1'b1;
        Load_Address = 9'h100;
        for (int k = 0; k < 4; k++) begin
            store(9'(9'h040 + 4 * k), 32'hC0DE_0000 + 32'(k), 2'b00, 1'b1);
            @(negedge clk);
            chk("t2_nostall", 32'(Load_Stall), 32'd0);
            chk("t2_nowrite", 32'(Mem_Write), 32'd0);
            tick();
        end
        store(9'h050, 32'hC0DE_0004, 2'b00, 1'b1);
        @(negedge clk);
        chk("t2_full_cnt", 32'(Count), 32'd4);
        chk("t2_full_rdy", 32'(Store_Ready), 32'd0);
        tick();
        Load_Valid = 1'b0;
        @(negedge clk);
        chk("t2_d0_cnt", 32'(Count), 32'd4);
        chk("t2_d0_rdy", 32'(Store_Ready), 32'd0);
        chk("t2_d0_wr", 32'(Mem_Write), 32'd1);
        tick();
        @(negedge clk);
        chk("t2_d1_cnt", 32'(Count), 32'd3);
        chk("t2_d1_rdy", 32'(Store_Ready), 32'd1);
        chk("t2_d1_wr", 32'(Mem_Write), 32'd1);
        tick();
        Store_Valid = 1'b0;
        @(negedge clk);
        chk("t2_d2_cnt", 32'(Count), 32'd3);
        chk("t2_d2_wr", 32'(Mem_Write), 32'd1);
        tick();
        @(negedge clk);
        chk("t2_d3_wr", 32'(Mem_Write), 32'd1);
        tick();
        @(negedge clk);
        chk("t2_d4_wr", 32'(Mem_Write), 32'd1);
        chk("t2_d4_cnt", 32'(Count), 32'd1);
        tick();
        @(negedge clk);
        chk("t2_empty", 32'(Buffer_Empty), 32'd1);

        // Byte store followed by a load to the same word.
        tick();
        store(9'h013, 32'h0000_00AB, 2'b11, 1'b1);
        tick();
        Store_Valid  = 1'b0;
        Load_Valid   = 1'b1;
        Load_Address = 9'h010;
        @(negedge clk);
        chk("t3_stall", 32'(Load_Stall), 32'd1);
        chk("t3_drain_addr", 32'(Mem_Address), 32'h013);
        tick();
        @(negedge clk);
        chk("t3_nostall", 32'(Load_Stall), 32'd0);
        chk("t3_load_addr", 32'(Mem_Address), 32'h010);
        chk("t3_nowrite", 32'(Mem_Write), 32'd0);

        // Load hazard against a push in the same cycle.
        tick();
        Load_Address = 9'h020;
        store(9'h022, 32'h0000_BEEF, 2'b10, 1'b1);
        @(negedge clk);
        chk("t4_stall", 32'(Load_Stall), 32'd1);
        chk("t4_nowrite", 32'(Mem_Write), 32'd0);
        chk("t4_addr", 32'(Mem_Address), 32'h020);
        tick();
        Store_Valid = 1'b0;
        Load_Valid  = 1'b0;
        wait_empty(10);

        // Back-to-back pushes wrap the pointers twice.
        tick();
        for (int k = 0; k < 10; k++) begin
            store(9'(9'h080 + 4 * k), 32'hA000_0000 + 32'(k), 2'b00, 1'b1);
            @(negedge clk);
            chk("t5_cnt_max", 32'(Count <= 3'd4), 32'd1);
            if (k > 0) chk("t5_cnt", 32'(Count), 32'd1);
            tick();
        end
        Store_Valid = 1'b0;
        wait_empty(10);

        // Reset with pending entries discards them.
        tick();
        Load_Valid   = 1'b1;
        Load_Address = 9'h1F0;
        for (int k = 0; k < 3; k++) begin
            store(9'(9'h0C0 + 4 * k), 32'hDEAD_0000 + 32'(k), 2'b00, 1'b0);
            tick();
        end
        Store_Valid = 1'b0;
        Load_Valid  = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        chk("t6_cnt_pre", 32'(Count), 32'd3);
        chk("t6_suppress", 32'(Mem_Write), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_cnt", 32'(Count), 32'd0);
        chk("t6_empty", 32'(Buffer_Empty), 32'd1);
        chk("t6_nowrite", 32'(Mem_Write), 32'd0);
        tick();
        @(negedge clk);
        chk("t6_nowrite2", 32'(Mem_Write), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
